// File: rtl/ramp_conv_pkg.sv
// Shared types and sizing helpers for the ramp/comparator conversion controller.
package ramp_conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DISCH = 3'd1,
        RAMP  = 3'd2,
        ACCUM = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Accumulator width that holds 2^avg_log2 full-scale samples without overflow.
    function automatic int unsigned acc_width(input int unsigned cnt_w, input int unsigned avg_log2);
        return cnt_w + avg_log2;
    endfunction

endpackage

// File: rtl/cdc_sync_ff.sv
// Multi-flop single-bit synchronizer for an asynchronous input, reset to 0.
module cdc_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/ramp_conv_ctrl.sv
// Sequences discharge/ramp conversions, averages 2^AVG_LOG2 counts and
// presents the result on a valid/ready interface.
module ramp_conv_ctrl #(
    parameter int unsigned CNT_W         = 5,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned DISCHARGE_CYC = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp,
    output logic             discharge,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_sat,
    output logic             result_valid,
    input  logic             result_ready
);

    import ramp_conv_pkg::*;

    localparam int unsigned ACC_W  = acc_width(CNT_W, AVG_LOG2);
    localparam int unsigned DISC_W = $clog2(DISCHARGE_CYC + 1);

    localparam logic [DISC_W-1:0]   DISC_LAST = DISC_W'(DISCHARGE_CYC - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [AVG_LOG2-1:0] IDX_LAST  = {AVG_LOG2{1'b1}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DISC_W-1:0]   disc_cnt_q, disc_cnt_d;
    logic [AVG_LOG2-1:0] conv_idx_q, conv_idx_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    sample_q, sample_d;
    logic                sat_acc_q, sat_acc_d;
    logic                discharge_d, busy_d;
    logic [CNT_W-1:0]    result_d;
    logic                result_sat_d, result_valid_d;
    logic                cmp_s;

    cdc_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_cmp_sync (
        .clk(clk),
        .rst(rst),
        .d  (cmp),
        .q  (cmp_s)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            disc_cnt_q   <= '0;
            conv_idx_q   <= '0;
            acc_q        <= '0;
            sample_q     <= '0;
            sat_acc_q    <= 1'b0;
            discharge    <= 1'b1;
            busy         <= 1'b0;
            result       <= '0;
            result_sat   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            disc_cnt_q   <= disc_cnt_d;
            conv_idx_q   <= conv_idx_d;
            acc_q        <= acc_d;
            sample_q     <= sample_d;
            sat_acc_q    <= sat_acc_d;
            discharge    <= discharge_d;
            busy         <= busy_d;
            result       <= result_d;
            result_sat   <= result_sat_d;
            result_valid <= result_valid_d;
        end
    end

    // Next-state, datapath updates and next output values.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        disc_cnt_d     = disc_cnt_q;
        conv_idx_d     = conv_idx_q;
        acc_d          = acc_q;
        sample_d       = sample_q;
        sat_acc_d      = sat_acc_q;
        result_d       = result;
        result_sat_d   = result_sat;
        result_valid_d = result_valid & ~result_ready;

        case (state_q)
            IDLE: begin
                if (start && (!result_valid || result_ready)) begin
                    acc_d      = '0;
                    conv_idx_d = '0;
                    sat_acc_d  = 1'b0;
                    disc_cnt_d = '0;
                    state_d    = DISCH;
                end
            end
            DISCH: begin
                if (disc_cnt_q == DISC_LAST) begin
                    cnt_d   = '0;
                    state_d = RAMP;
                end else begin
                    disc_cnt_d = disc_cnt_q + 1'b1;
                end
            end
            RAMP: begin
                if (cmp_s) begin
                    sample_d = cnt_q;
                    state_d  = ACCUM;
                end else if (cnt_q == CNT_MAX) begin
                    sample_d  = CNT_MAX;
                    sat_acc_d = 1'b1;
                    state_d   = ACCUM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(sample_q);
                if (conv_idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    conv_idx_d = conv_idx_q + 1'b1;
                    disc_cnt_d = '0;
                    state_d    = DISCH;
                end
            end
            DONE: begin
                result_d       = acc_q[ACC_W-1:AVG_LOG2];
                result_sat_d   = sat_acc_q;
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The ramp runs only in RAMP; every other state keeps it discharged.
        discharge_d = (state_d != RAMP);
        busy_d      = (state_d != IDLE);
    end

endmodule

// File: tb/tb_ramp_conv_ctrl.sv
// Self-checking bench for ramp_conv_ctrl with a behavioural ramp/comparator model.
module tb_ramp_conv_ctrl;

    localparam int CNT_W         = 5;
    localparam int AVG_LOG2      = 2;
    localparam int DISCHARGE_CYC = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int N_CONV        = 1 << AVG_LOG2;
    localparam int SAT           = (1 << CNT_W) - 1;
    localparam int NEVER         = -1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cmp;
    logic             discharge;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_sat;
    logic             result_valid;
    logic             result_ready;

    int errors = 0;
    int checks = 0;

    // Comparator delay (cycles after discharge falls) per conversion; NEVER = stays low.
    int dly[N_CONV];

    // Analog model state.
    int a_age;
    int a_ramp;
    bit a_prev;
    bit a_stuck;
    int fall_at[8];

    // Last expected result and whether it is still unconsumed.
    int last_res;
    bit last_sat;
    bit pending;

    always #5 clk = ~clk;

    ramp_conv_ctrl #(
        .CNT_W        (CNT_W),
        .AVG_LOG2     (AVG_LOG2),
        .DISCHARGE_CYC(DISCHARGE_CYC),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cmp         (cmp),
        .discharge   (discharge),
        .busy        (busy),
        .result      (result),
        .result_sat  (result_sat),
        .result_valid(result_valid),
        .result_ready(result_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic analog_reset(input bit stuck);
        a_age   = -1;
        a_ramp  = 0;
        a_prev  = 1'b1;
        a_stuck = stuck;
        cmp     = stuck;
    endtask

    // Ramp/comparator behaviour: cmp low while discharged, rises dly cycles after discharge falls.
    task automatic analog_tick(input int j);
        if (discharge) begin
            a_age = -1;
            cmp   = a_stuck;
        end else begin
            if (a_prev) begin
                a_age = 0;
                if (a_ramp < 8) fall_at[a_ramp] = j;
                a_ramp++;
            end else begin
                a_age++;
            end
            if (!a_stuck && a_ramp <= N_CONV && dly[a_ramp-1] >= 0 && a_age == dly[a_ramp-1])
                cmp = 1'b1;
        end
        a_prev = discharge;
    endtask

    // One averaged measurement using dly[], checked against arithmetic expectations.
    task automatic measure(input string name, input bit stuck, input bit with_ready);
        int exp_s[N_CONV];
        int sum     = 0;
        bit exp_sat = 1'b0;
        int exp_lat = 1;
        int exp_res;
        int j       = 0;
        bit seen    = 1'b0;
        for (int i = 0; i < N_CONV; i++) begin
            if (stuck) begin
                exp_s[i] = 0;
            end else if (dly[i] < 0 || dly[i] + SYNC_STAGES > SAT) begin
                exp_s[i] = SAT;
                exp_sat  = 1'b1;
            end else begin
                exp_s[i] = dly[i] + SYNC_STAGES;
            end
            sum     += exp_s[i];
            exp_lat += DISCHARGE_CYC + exp_s[i] + 2;
        end
        exp_res = sum >> AVG_LOG2;

        analog_reset(stuck);
        start        = 1'b1;
        result_ready = with_ready;
        step();
        start        = 1'b0;
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_busy: got %b expected 1", name, busy);
        end
        if (with_ready) begin
            checks++;
            if (result_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s handshake_drop: result_valid got %b expected 0", name, result_valid);
            end
        end

        while (j < exp_lat + 200) begin
            analog_tick(j);
            if (result_valid) begin
                seen = 1'b1;
                break;
            end
            step();
            j++;
        end

        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no result_valid within %0d cycles", name, exp_lat + 200);
        end
        checks++;
        if (j != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, j, exp_lat);
        end
        checks++;
        if (result !== CNT_W'(exp_res)) begin
            errors++;
            $display("FAIL %s result: got %0d expected %0d", name, result, exp_res);
        end
        checks++;
        if (result_sat !== exp_sat) begin
            errors++;
            $display("FAIL %s result_sat: got %b expected %b", name, result_sat, exp_sat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_valid: got %b expected 0", name, busy);
        end
        checks++;
        if (a_ramp != N_CONV) begin
            errors++;
            $display("FAIL %s ramp_count: got %0d expected %0d", name, a_ramp, N_CONV);
        end
        if (a_ramp >= 1) begin
            checks++;
            if (fall_at[0] != DISCHARGE_CYC) begin
                errors++;
                $display("FAIL %s first_discharge: ramp began %0d cycles after accept, expected %0d",
                         name, fall_at[0], DISCHARGE_CYC);
            end
        end
        // Spacing between ramp starts: previous ramp, one accumulate cycle, then the discharge hold.
        for (int i = 1; i < N_CONV && i < a_ramp; i++) begin
            checks++;
            if (fall_at[i] - fall_at[i-1] != exp_s[i-1] + 1 + 1 + DISCHARGE_CYC) begin
                errors++;
                $display("FAIL %s ramp_spacing[%0d]: got %0d expected %0d", name, i,
                         fall_at[i] - fall_at[i-1], exp_s[i-1] + 2 + DISCHARGE_CYC);
            end
        end
        cmp      = 1'b0;
        last_res = exp_res;
        last_sat = exp_sat;
        pending  = 1'b1;
    endtask

    task automatic consume();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume_valid: got %b expected 0", result_valid);
        end
        checks++;
        if (result !== CNT_W'(last_res) || result_sat !== last_sat) begin
            errors++;
            $display("FAIL consume_hold: got %0d/%b expected %0d/%b", result, result_sat, last_res, last_sat);
        end
        pending = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cmp = 1'b0; result_ready = 1'b0;
        step();
        step();
        checks++;
        if (discharge !== 1'b1 || busy !== 1'b0 || result !== '0 || result_sat !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: dis=%b busy=%b res=%0d sat=%b valid=%b expected 1 0 0 0 0",
                     discharge, busy, result, result_sat, result_valid);
        end
        rst = 1'b0;
        pending = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        dly = '{6, 6, 6, 6};
        measure("nominal", 1'b0, 1'b0);
        consume();
    endtask

    task automatic test_averaging();
        dly = '{5, 6, 7, 10};
        measure("avg_36", 1'b0, 1'b0);
        dly = '{5, 5, 5, 6};
        measure("avg_29", 1'b0, 1'b1);
        consume();
    endtask

    task automatic test_saturation();
        dly = '{NEVER, NEVER, NEVER, NEVER};
        measure("sat_all", 1'b0, 1'b0);
        dly = '{6, 6, 6, 6};
        measure("sat_clear", 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 20; c++) begin
            start = (c % 3 == 0);
            step();
            start = 1'b0;
            checks++;
            if (result_valid !== 1'b1 || result !== CNT_W'(last_res) || busy !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b res=%0d busy=%b expected 1 %0d 0",
                         c, result_valid, result, busy, last_res);
            end
        end
        dly = '{6, 7, 8, 9};
        measure("bp_restart", 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_ramp();
        int j   = 0;
        bit hit = 1'b0;
        dly = '{6, 6, 6, 6};
        analog_reset(1'b0);
        start        = 1'b1;
        result_ready = 1'b1;
        step();
        start        = 1'b0;
        result_ready = 1'b0;
        while (j < 400) begin
            analog_tick(j);
            if (a_ramp == 2 && a_age == 2) begin
                hit = 1'b1;
                break;
            end
            step();
            j++;
        end
        checks++;
        if (!hit || discharge !== 1'b0) begin
            errors++;
            $display("FAIL midramp_reach: hit=%b discharge=%b expected 1 0", hit, discharge);
        end
        rst = 1'b1;
        step();
        checks++;
        if (discharge !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || result !== '0 || result_sat !== 1'b0) begin
            errors++;
            $display("FAIL midramp_reset: dis=%b busy=%b valid=%b res=%0d sat=%b expected 1 0 0 0 0",
                     discharge, busy, result_valid, result, result_sat);
        end
        rst     = 1'b0;
        cmp     = 1'b0;
        pending = 1'b0;
        step();
        measure("after_reset", 1'b0, 1'b0);
        consume();
    endtask

    task automatic test_stuck();
        dly = '{0, 0, 0, 0};
        measure("stuck", 1'b1, 1'b0);
        consume();
    endtask

    task automatic test_random();
        bit wr;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < N_CONV; i++) begin
                if ($urandom_range(0, 7) == 0) dly[i] = NEVER;
                else dly[i] = int'($urandom_range(0, 34));
            end
            wr = 1'($urandom_range(0, 1));
            if (!wr && pending) consume();
            measure("random", 1'b0, wr);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_averaging();
        test_saturation();
        test_backpressure();
        test_reset_mid_ramp();
        test_stuck();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
